// File: rtl/spi_transaction_controller.sv
// SPI slave frame sequencer: counts bits, decodes the command byte and turns
// following bytes into register-file writes or reads with address auto-increment.
module spi_transaction_controller #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              CLK,
  input  logic              _RST,
  input  logic              _CS,
  input  logic              SCK_RISE,
  input  logic [7:0]        RXByte,
  input  logic [7:0]        RegRdData,
  output logic              _HOLD,
  output logic [7:0]        TXData,
  output logic [ADDR_W-1:0] RegAddr,
  output logic [7:0]        RegWrData,
  output logic              RegWrEn,
  output logic              CmdErr
);

  typedef enum logic [2:0] {IDLE, CMD, WR, RD, IGNORE} state_t;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  state_t      state, stateNxt;
  logic [2:0]  BitCnt;
  logic        ByteDone;
  logic        rdLoad;
  logic        cmdBad;
  logic        decode, wrByte, rdAdv, clrErr;
  logic [ADDR_W-1:0] addrInc;

  // Shift registers only move while the slave is selected
  assign _HOLD   = _CS;
  assign cmdBad  = {1'b0, RXByte[6:0]} >= 8'(NUM_REGS);
  assign addrInc = (RegAddr == LastAddr) ? '0 : RegAddr + 1'b1;

  // State register
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) state <= IDLE;
    else       state <= stateNxt;
  end

  // Next-state and per-cycle action decode; a _CS rise always aborts to IDLE,
  // but a ByteDone already pending in that cycle still gets its action
  always_comb begin
    stateNxt = state;
    decode   = 1'b0;
    wrByte   = 1'b0;
    rdAdv    = 1'b0;
    clrErr   = 1'b0;
    case (state)
      IDLE: if (!_CS) begin
        stateNxt = CMD;
        clrErr   = 1'b1;
      end
      CMD: if (ByteDone) begin
        decode   = 1'b1;
        stateNxt = cmdBad ? IGNORE : (RXByte[7] ? WR : RD);
      end
      WR:      if (ByteDone) wrByte = 1'b1;
      RD:      if (ByteDone) rdAdv  = 1'b1;
      default: ;
    endcase
    if (_CS) stateNxt = IDLE;
  end

  // Bit counter and byte-boundary pulse; SCK edges are ignored while deselected
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      BitCnt   <= '0;
      ByteDone <= 1'b0;
    end else if (_CS) begin
      BitCnt   <= '0;
      ByteDone <= 1'b0;
    end else begin
      ByteDone <= SCK_RISE && (BitCnt == 3'd7);
      if (SCK_RISE) BitCnt <= BitCnt + 3'd1;
    end
  end

  // Register-file datapath: address, write strobe, TX reload and error flag
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      RegAddr   <= '0;
      RegWrData <= '0;
      RegWrEn   <= 1'b0;
      TXData    <= '0;
      CmdErr    <= 1'b0;
      rdLoad    <= 1'b0;
    end else begin
      RegWrEn <= wrByte;
      if (wrByte) RegWrData <= RXByte;
      // Reload TX one cycle after the read address is set or advanced, so
      // RegRdData already reflects the new address
      rdLoad <= (decode && !cmdBad && !RXByte[7]) || rdAdv;
      if (rdLoad && state == RD) TXData <= RegRdData;
      if (clrErr)                CmdErr <= 1'b0;
      else if (decode && cmdBad) CmdErr <= 1'b1;
      // Write address advances the cycle after its strobe
      if (decode && !cmdBad)     RegAddr <= RXByte[ADDR_W-1:0];
      else if (RegWrEn || rdAdv) RegAddr <= addrInc;
    end
  end

endmodule

// File: tb/tb_spi_transaction_controller.sv
// Directed bench for spi_transaction_controller with a behavioural register file.
module tb_spi_transaction_controller;

  logic       CLK = 1'b0;
  logic       _RST = 1'b0;
  logic       _CS = 1'b1;
  logic       SCK_RISE = 1'b0;
  logic [7:0] RXByte = 8'h00;
  logic [7:0] RegRdData;
  logic       _HOLD;
  logic [7:0] TXData;
  logic [2:0] RegAddr;
  logic [7:0] RegWrData;
  logic       RegWrEn;
  logic       CmdErr;

  int total = 0;
  int bad   = 0;

  logic [7:0] regs [8];
  int         wrA[$];
  logic [7:0] wrD[$];

  spi_transaction_controller #(.NUM_REGS(8), .ADDR_W(3)) dut (
    .CLK(CLK), ._RST(_RST), ._CS(_CS), .SCK_RISE(SCK_RISE), .RXByte(RXByte),
    .RegRdData(RegRdData), ._HOLD(_HOLD), .TXData(TXData), .RegAddr(RegAddr),
    .RegWrData(RegWrData), .RegWrEn(RegWrEn), .CmdErr(CmdErr)
  );

  always #5 CLK = ~CLK;

  // Register file model with write log
  assign RegRdData = regs[RegAddr];
  always @(posedge CLK) begin
    if (RegWrEn) begin
      regs[RegAddr] <= RegWrData;
      wrA.push_back(int'(RegAddr));
      wrD.push_back(RegWrData);
    end
  end

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK) SCK_RISE = 1'b1;
      @(negedge CLK) SCK_RISE = 1'b0;
      repeat (4) @(negedge CLK);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    RXByte = b;
    pulses(8);
  endtask

  task automatic startFrame();
    @(negedge CLK) _CS = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic endFrame();
    @(negedge CLK) _CS = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic chkWr(input string nm, input int idx, input int expA, input logic [7:0] expD);
    total++;
    if (idx >= wrA.size()) begin
      bad++;
      $display("FAIL %s: write #%0d missing, got %0d writes", nm, idx, wrA.size());
    end else if (wrA[idx] != expA || wrD[idx] !== expD) begin
      bad++;
      $display("FAIL %s: got addr=%0d data=%h, want addr=%0d data=%h",
               nm, wrA[idx], wrD[idx], expA, expD);
    end
  endtask

  task automatic test_reset();
    _RST = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if ({TXData, RegAddr, RegWrEn, CmdErr} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs: got tx=%h addr=%0d we=%b err=%b, want all 0",
               TXData, RegAddr, RegWrEn, CmdErr);
    end
    total++;
    if (_HOLD !== 1'b1) begin bad++; $display("FAIL reset_hold: got %b want 1", _HOLD); end
    _RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_write();
    int base = wrA.size();
    startFrame();
    total++;
    if (_HOLD !== 1'b0) begin bad++; $display("FAIL hold_follow_cs: got %b want 0", _HOLD); end
    sendByte(8'h82); sendByte(8'h11); sendByte(8'h22);
    endFrame();
    total++;
    if (wrA.size() - base != 2) begin
      bad++; $display("FAIL write_count: got %0d want 2", wrA.size() - base);
    end
    chkWr("write_b0", base, 2, 8'h11);
    chkWr("write_b1", base + 1, 3, 8'h22);
    total++;
    if (CmdErr !== 1'b0) begin bad++; $display("FAIL write_cmderr: got %b want 0", CmdErr); end
  endtask

  task automatic test_read();
    int base;
    // Preload regs 5..7 through the DUT itself
    startFrame();
    sendByte(8'h85); sendByte(8'hA5); sendByte(8'h3C); sendByte(8'h77);
    endFrame();
    base = wrA.size();
    startFrame();
    sendByte(8'h05);
    total++;
    if (TXData !== 8'hA5) begin bad++; $display("FAIL read_b0: got %h want a5", TXData); end
    sendByte(8'hFF);
    total++;
    if (TXData !== 8'h3C) begin bad++; $display("FAIL read_b1: got %h want 3c", TXData); end
    sendByte(8'hFF);
    total++;
    if (TXData !== 8'h77) begin bad++; $display("FAIL read_b2: got %h want 77", TXData); end
    endFrame();
    total++;
    if (TXData !== 8'h77) begin bad++; $display("FAIL read_hold_idle: got %h want 77", TXData); end
    total++;
    if (wrA.size() != base) begin
      bad++; $display("FAIL read_no_write: got %0d writes want 0", wrA.size() - base);
    end
  endtask

  task automatic test_wrap();
    int base = wrA.size();
    startFrame();
    sendByte(8'h87); sendByte(8'hAA); sendByte(8'hBB);
    endFrame();
    chkWr("wrap_b0", base, 7, 8'hAA);
    chkWr("wrap_b1", base + 1, 0, 8'hBB);
  endtask

  task automatic test_bad_addr();
    int base = wrA.size();
    startFrame();
    sendByte(8'h8A);
    total++;
    if (CmdErr !== 1'b1) begin bad++; $display("FAIL bad_cmderr_set: got %b want 1", CmdErr); end
    sendByte(8'h55);
    endFrame();
    total++;
    if (CmdErr !== 1'b1) begin bad++; $display("FAIL bad_cmderr_sticky: got %b want 1", CmdErr); end
    total++;
    if (wrA.size() != base) begin
      bad++; $display("FAIL bad_no_write: got %0d writes want 0", wrA.size() - base);
    end
    startFrame();
    total++;
    if (CmdErr !== 1'b0) begin bad++; $display("FAIL bad_cmderr_clear: got %b want 0", CmdErr); end
    endFrame();
  endtask

  task automatic test_abort();
    int base = wrA.size();
    startFrame();
    sendByte(8'h81);
    RXByte = 8'hEE;
    pulses(5);
    endFrame();
    total++;
    if (wrA.size() != base) begin
      bad++; $display("FAIL abort_no_write: got %0d writes want 0", wrA.size() - base);
    end
    // A misaligned bit counter would shift every later byte boundary
    startFrame();
    sendByte(8'h84); sendByte(8'h99);
    endFrame();
    chkWr("abort_fresh_cmd", base, 4, 8'h99);
  endtask

  task automatic test_reset_mid();
    int base = wrA.size();
    startFrame();
    sendByte(8'h83);
    RXByte = 8'h12;
    pulses(5);
    @(negedge CLK) _RST = 1'b0;
    #1;
    total++;
    if ({TXData, RegAddr, RegWrEn, CmdErr} !== 13'h0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got tx=%h addr=%0d we=%b err=%b, want all 0",
               TXData, RegAddr, RegWrEn, CmdErr);
    end
    total++;
    if (_HOLD !== 1'b0) begin bad++; $display("FAIL rst_mid_hold: got %b want 0", _HOLD); end
    _CS = 1'b1;
    repeat (2) @(negedge CLK);
    _RST = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if (wrA.size() != base) begin
      bad++; $display("FAIL rst_mid_no_write: got %0d writes want 0", wrA.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_bad_addr();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
